// File: rtl/instr_fetch_unit_if.sv
// Fetch-stage bus: instruction-memory port, execute redirect, and the decode handshake.
// The master modport is the fetch unit; slave is the memory/execute/decode side.
interface instr_fetch_unit_if;
  logic [31:0] imem_addr_o;
  logic [31:0] imem_data_i;
  logic        redirect_valid_i;
  logic [31:0] redirect_pc_i;
  logic        instr_valid_o;
  logic        instr_ready_i;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;
  logic        fetch_done_o;

  modport master (
    output imem_addr_o,
    input  imem_data_i,
    input  redirect_valid_i,
    input  redirect_pc_i,
    output instr_valid_o,
    input  instr_ready_i,
    output instr_o,
    output instr_pc_o,
    output fetch_done_o
  );

  modport slave (
    input  imem_addr_o,
    output imem_data_i,
    output redirect_valid_i,
    output redirect_pc_i,
    input  instr_valid_o,
    output instr_ready_i,
    input  instr_o,
    input  instr_pc_o,
    input  fetch_done_o
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// RV32I fetch stage: PC register, combinational imem address, and a small circular
// buffer of {pc, instr} entries drained by decode; redirects flush and re-steer.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned MEM_SIZE = 80,
  parameter int unsigned DEPTH    = 2
) (
  input logic                  clk_i,
  input logic                  rst_i,
  instr_fetch_unit_if.master   bus
);

  localparam int unsigned PtrW  = $clog2(DEPTH);
  localparam int unsigned CntW  = $clog2(DEPTH + 1);
  localparam logic [31:0] Limit = 32'(MEM_SIZE * 4);
  localparam logic [31:0] Nop   = 32'h0000_0013;

  logic [31:0]     pc_q, pc_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic [31:0]     buf_pc_q    [DEPTH];
  logic [31:0]     buf_instr_q [DEPTH];

  logic in_range;
  logic pop;
  logic push;
  logic not_empty;

  always_comb begin
    not_empty = (count_q != '0);
    in_range  = (pc_q < Limit);
    pop       = not_empty & bus.instr_ready_i;
    // A full buffer still accepts a push when the head leaves this cycle.
    push      = in_range & ~bus.redirect_valid_i & ((count_q < CntW'(DEPTH)) | pop);
  end

  always_comb begin
    pc_d     = pc_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (bus.redirect_valid_i) begin
      pc_d     = {bus.redirect_pc_i[31:2], 2'b00};
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        pc_d     = pc_q + 32'd4;
        wr_ptr_d = wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PtrW'(1);
      end
      count_d = count_q + CntW'(push) - CntW'(pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_q     <= RESET_PC;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      pc_q     <= pc_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry contents need no reset; count gates visibility.
  always_ff @(posedge clk_i) begin
    if (push) begin
      buf_pc_q[wr_ptr_q]    <= pc_q;
      buf_instr_q[wr_ptr_q] <= bus.imem_data_i;
    end
  end

  always_comb begin
    bus.imem_addr_o   = pc_q;
    bus.instr_valid_o = not_empty;
    bus.instr_o       = Nop;
    bus.instr_pc_o    = 32'h0;
    if (not_empty) begin
      bus.instr_o    = buf_instr_q[rd_ptr_q];
      bus.instr_pc_o = buf_pc_q[rd_ptr_q];
    end
    bus.fetch_done_o = ~in_range & ~not_empty;
  end

endmodule
